// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit queue: FSM state encodings and
// the default board-level uart constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    WAIT_DONE  = 2'd2,
    GAP        = 2'd3
  } tx_state_e;

  localparam int unsigned BAUD    = 32'd9600;
  localparam int unsigned SYS_CLK = 32'd12000000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with a registered look-ahead head. The storage array
// has no reset so it can map onto block RAM; the head register always holds
// the entry the next pop will return, bypassing the array when that entry is
// being written in the same cycle.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_next;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty = (count == (DEPTH_LOG2+1)'(0));

  // Qualify push/pop; a push into a full queue is accepted only alongside a pop.
  always_comb begin
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    rd_ptr_next = rd_ptr;
    if (pop && !empty && !flush) begin
      rd_en       = 1'b1;
      rd_ptr_next = rd_ptr + 1'b1;
    end else begin
      rd_en       = 1'b0;
      rd_ptr_next = rd_ptr;
    end
    if (push && !flush && (!full || rd_en)) begin
      wr_en = 1'b1;
    end else begin
      wr_en = 1'b0;
    end
  end

  // Storage write port, deliberately without reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Look-ahead head: next entry to pop, taken from the bypass when it is the slot being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (wr_en && (wr_ptr == rd_ptr_next)) begin
      head <= push_data;
    end else begin
      head <= mem[rd_ptr_next];
    end
  end

  // Pointers, occupancy and sticky overflow; flush clears all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_next;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !rd_en) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue in front of the uart transmitter: buffers bytes pushed by the
// monitor and issues one transmit pulse per byte, each only after the
// previous frame has finished plus an idle gap.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  busy,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  is_transmitting
);

  localparam logic [7:0] GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  tx_state_e  state;
  tx_state_e  next_state;
  logic       pop;
  logic [7:0] head;
  logic [7:0] gap_cnt;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  assign busy = (state != IDLE) || !empty;

  // Next-state logic; a pop is requested only from IDLE with the uart quiet.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !is_transmitting && !flush) begin
          pop        = 1'b1;
          next_state = WAIT_START;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_START: begin
        if (is_transmitting) begin
          next_state = WAIT_DONE;
        end else begin
          next_state = WAIT_START;
        end
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          next_state = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) begin
          next_state = IDLE;
        end else begin
          next_state = GAP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, registered transmit pulse / byte, and the gap down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      transmit <= 1'b0;
      tx_byte  <= 8'h00;
      gap_cnt  <= 8'd0;
    end else begin
      state    <= next_state;
      transmit <= pop;
      if (pop) begin
        tx_byte <= head;
      end
      if ((state == WAIT_DONE) && (next_state == GAP)) begin
        gap_cnt <= GAP_INIT;
      end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple uart model. The frame length
// is scaled down from a real 9600-baud frame to keep the run short.
module tb_uart_tx_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int GAP_CYCLES = 1;
  localparam int FRAME      = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       flush = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       busy;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       is_transmitting;

  logic       uart_busy = 1'b0;
  logic       stall = 1'b0;
  int         frame_cnt = 0;
  logic       prev_tx = 1'b0;
  int         idle_cnt = 1000;
  logic [7:0] log_q[$];

  int checks = 0;
  int passed = 0;

  assign is_transmitting = uart_busy | stall;

  uart_tx_queue #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .push_data       (push_data),
    .flush           (flush),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .overflow        (overflow),
    .busy            (busy),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // Uart model: raises is_transmitting the cycle after a pulse, holds it FRAME cycles.
  always @(posedge clk) begin
    if (uart_busy) begin
      if (frame_cnt == 1) uart_busy <= 1'b0;
      frame_cnt <= frame_cnt - 1;
    end else if (transmit) begin
      uart_busy <= 1'b1;
      frame_cnt <= FRAME;
    end
  end

  // Transmit monitor: logs bytes, checks pulse width and the post-frame gap.
  always @(negedge clk) begin
    if (rst_n && transmit) begin
      log_q.push_back(tx_byte);
      check("no_back_to_back", {31'd0, prev_tx}, 32'd0);
      check("gap_respected", {31'd0, (idle_cnt >= GAP_CYCLES)}, 32'd1);
    end
    prev_tx <= transmit;
    if (is_transmitting) idle_cnt <= 0;
    else if (!transmit) idle_cnt <= idle_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_tx_level(input logic lvl, input string tag);
    int n = 0;
    while ((is_transmitting !== lvl) && (n < 500)) begin
      tick();
      n++;
    end
    check(tag, {31'd0, is_transmitting}, {31'd0, lvl});
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int c = 0;
    while ((log_q.size() < n) && (c < budget)) begin
      tick();
      c++;
    end
    check(tag, log_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || is_transmitting) && (n < 2000)) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy | is_transmitting}, 32'd0);
  endtask

  initial begin
    int n;

    // 1. reset values, then reset in the middle of a frame
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_transmit", transmit, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    push_byte(8'h41);
    push_byte(8'h42);
    wait_tx_level(1'b1, "t1_frame_start");
    check("t1_pre_count", count, 1);
    rst_n = 1'b0;
    #1;
    check("t1_async_count", count, 0);
    check("t1_async_empty", empty, 1);
    check("t1_async_tx_byte", tx_byte, 8'h00);
    check("t1_async_busy", busy, 0);
    check("t1_async_transmit", transmit, 0);
    tick();
    rst_n = 1'b1;
    log_q.delete();
    push_byte(8'h43);
    wait_tx_level(1'b0, "t1_frame_end");
    check("t1_no_tx_during_frame", log_q.size(), 0);
    wait_log(1, 20, "t1_tx_after_frame");
    check("t1_byte", log_q[0], 8'h43);
    wait_idle("t1_idle");

    // 2. single byte latency and busy release
    log_q.delete();
    push_byte(8'h41);
    check("t2_count_after_push", count, 1);
    check("t2_no_tx_yet", transmit, 0);
    tick();
    check("t2_transmit", transmit, 1);
    check("t2_tx_byte", tx_byte, 8'h41);
    check("t2_count_after_pop", count, 0);
    check("t2_empty", empty, 1);
    wait_tx_level(1'b1, "t2_frame_start");
    wait_tx_level(1'b0, "t2_frame_end");
    n = 0;
    while (busy && (n < 50)) begin
      tick();
      n++;
    end
    check("t2_busy_release_cycles", n, GAP_CYCLES + 1);

    // 3. burst of 16 bytes while the uart is held busy, then drain
    log_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    check("t3_full", full, 1);
    check("t3_count", count, 16);
    check("t3_overflow", overflow, 0);
    stall = 1'b0;
    wait_log(16, 16 * (FRAME + 10), "t3_pulses");
    for (int i = 0; i < 16; i++) check("t3_order", log_q[i], 8'(i));
    wait_idle("t3_idle");

    // 4. overflow on the 17th push, then flush
    log_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 17; i++) push_byte(8'(8'h20 + i));
    check("t4_count", count, 16);
    check("t4_overflow", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_flush_count", count, 0);
    check("t4_flush_overflow", overflow, 0);
    check("t4_flush_empty", empty, 1);
    stall = 1'b0;
    repeat (2 * FRAME) tick();
    check("t4_nothing_sent", log_q.size(), 0);

    // 5. full queue: push in the same cycle as the pop
    log_q.delete();
    stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h50 + i));
    check("t5_full", full, 1);
    stall = 1'b0;
    push_byte(8'hAA);
    check("t5_transmit", transmit, 1);
    check("t5_count", count, 16);
    check("t5_overflow", overflow, 0);
    wait_log(17, 17 * (FRAME + 10), "t5_pulses");
    for (int i = 0; i < 17; i++)
      check("t5_order", log_q[i], (i < 16) ? 8'(8'h50 + i) : 8'hAA);
    wait_idle("t5_idle");

    // 6. flush with push while the first of three bytes is in flight
    log_q.delete();
    push_byte(8'h61);
    push_byte(8'h62);
    push_byte(8'h63);
    wait_tx_level(1'b1, "t6_frame_start");
    check("t6_pre_count", count, 2);
    flush = 1'b1;
    push = 1'b1;
    push_data = 8'hEE;
    tick();
    flush = 1'b0;
    push = 1'b0;
    check("t6_count", count, 0);
    check("t6_overflow", overflow, 0);
    check("t6_empty", empty, 1);
    wait_tx_level(1'b0, "t6_frame_end");
    repeat (3 * FRAME) tick();
    check("t6_one_sent", log_q.size(), 1);
    check("t6_byte", log_q[0], 8'h61);
    check("t6_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
